// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown with load/start/pause/clear commands.
// A prescaler divides clk by TICK_DIV to produce one-second decrements.
`default_nettype none

module countdown_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] set_mindec,
  input  logic [3:0] set_min,
  input  logic [3:0] set_segdec,
  input  logic [3:0] set_seg,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] mindec,
  output logic [3:0] min,
  output logic [3:0] segdec,
  output logic [3:0] seg,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       expired,
  output logic       load_err
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t          state;
  state_t          nxt_state;
  logic [15:0]     tm;
  logic [PW-1:0]   cnt;
  logic [15:0]     dec;
  logic            load_act;
  logic            load_ok;
  logic            pause_act;
  logic            start_act;
  logic            wrap;
  logic            reach_zero;

  // One-second BCD decrement with borrow; only applied to a nonzero time.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] md, m, sd, s;
    {md, m, sd, s} = t;
    if (s != 4'd0) begin
      s = s - 4'd1;
    end else begin
      s = 4'd9;
      if (sd != 4'd0) begin
        sd = sd - 4'd1;
      end else begin
        sd = 4'd5;
        if (m != 4'd0) begin
          m = m - 4'd1;
        end else begin
          m  = 4'd9;
          md = md - 4'd1;
        end
      end
    end
    return {md, m, sd, s};
  endfunction

  always_comb begin
    load_act   = load && !clear && (state != RUN);
    load_ok    = (set_mindec <= 4'd5) && (set_min <= 4'd9) &&
                 (set_segdec <= 4'd5) && (set_seg <= 4'd9);
    pause_act  = pause && !clear && (state == RUN);
    start_act  = start && !clear && !load_act && (tm != 16'd0) &&
                 ((state == IDLE) || (state == PAUSED));
    // A pause on the wrap cycle suppresses the decrement.
    wrap       = (state == RUN) && !clear && !pause_act && (cnt == LAST);
    dec        = bcd_dec(tm);
    reach_zero = wrap && (dec == 16'd0);

    nxt_state = state;
    if (clear) begin
      nxt_state = IDLE;
    end else if (load_act) begin
      if (load_ok) nxt_state = IDLE;
    end else if (pause_act) begin
      nxt_state = PAUSED;
    end else if (start_act) begin
      nxt_state = RUN;
    end else if (reach_zero) begin
      nxt_state = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tm       <= 16'd0;
      cnt      <= '0;
      running  <= 1'b0;
      paused   <= 1'b0;
      done     <= 1'b0;
      expired  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= nxt_state;
      running  <= (nxt_state == RUN);
      paused   <= (nxt_state == PAUSED);
      done     <= (nxt_state == DONE);
      expired  <= reach_zero;
      load_err <= load_act && !load_ok;

      if (clear) begin
        tm  <= 16'd0;
        cnt <= '0;
      end else if (load_act && load_ok) begin
        tm  <= {set_mindec, set_min, set_segdec, set_seg};
        cnt <= '0;
      end else if (start_act && (state == IDLE)) begin
        cnt <= '0;
      end else if (wrap) begin
        tm  <= dec;
        cnt <= '0;
      end else if ((state == RUN) && !pause_act) begin
        cnt <= cnt + ONE;
      end
    end
  end

  assign {mindec, min, segdec, seg} = tm;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with TICK_DIV=4.
`default_nettype none

module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] set_mindec = 4'd0, set_min = 4'd0, set_segdec = 4'd0, set_seg = 4'd0;
  logic [3:0] mindec, min, segdec, seg;
  logic       running, paused, done, expired, load_err;

  int checks = 0;
  int failures = 0;

  countdown_timer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load),
    .set_mindec(set_mindec), .set_min(set_min), .set_segdec(set_segdec), .set_seg(set_seg),
    .start(start), .pause(pause),
    .mindec(mindec), .min(min), .segdec(segdec), .seg(seg),
    .running(running), .paused(paused), .done(done),
    .expired(expired), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_time(input logic [15:0] t);
    {set_mindec, set_min, set_segdec, set_seg} = t;
  endtask

  function automatic logic [15:0] tm();
    return {mindec, min, segdec, seg};
  endfunction

  function automatic logic [2:0] fl();
    return {running, paused, done};
  endfunction

  initial begin
    #2;
    chk("reset_time", tm(), 16'h0000);
    chk("reset_flags", {fl(), expired, load_err}, 5'b00000);
    #10 rst = 1'b0;

    // 01:05 countdown across a minute boundary
    set_time(16'h0105); load = 1'b1; tick(1); load = 1'b0;
    chk("load_0105", tm(), 16'h0105);
    chk("load_idle", fl(), 3'b000);
    start = 1'b1; tick(1); start = 1'b0;
    chk("start_run", fl(), 3'b100);
    tick(3);
    chk("pre_first_dec", tm(), 16'h0105);
    tick(1);
    chk("first_dec", tm(), 16'h0104);
    tick(16);
    chk("dec_0100", tm(), 16'h0100);
    tick(4);
    chk("borrow_0059", tm(), 16'h0059);

    // load while running is ignored silently
    set_time(16'h0200); load = 1'b1; tick(1); load = 1'b0;
    chk("load_in_run_time", tm(), 16'h0059);
    chk("load_in_run_flags", {fl(), load_err}, 4'b1000);

    // clear beats load in the same cycle
    set_time(16'h0300); clear = 1'b1; load = 1'b1; tick(1); clear = 1'b0; load = 1'b0;
    chk("clear_load_time", tm(), 16'h0000);
    chk("clear_load_flags", {fl(), load_err}, 4'b0000);

    // 00:02 runs to expiry
    set_time(16'h0002); load = 1'b1; tick(1); load = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    tick(7);
    chk("exp_pre_time", tm(), 16'h0001);
    chk("exp_pre_flags", {fl(), expired}, 4'b1000);
    tick(1);
    chk("exp_time", tm(), 16'h0000);
    chk("exp_flags", {fl(), expired}, 4'b0011);
    tick(1);
    chk("exp_pulse_end", {fl(), expired}, 4'b0010);
    start = 1'b1; tick(1); start = 1'b0;
    chk("start_in_done", {fl(), tm()}, {3'b001, 16'h0000});

    // rejected loads
    clear = 1'b1; tick(1); clear = 1'b0;
    set_time(16'h0060); load = 1'b1; tick(1); load = 1'b0;
    chk("bad_segdec_err", load_err, 1'b1);
    chk("bad_segdec_keep", {fl(), tm()}, {3'b000, 16'h0000});
    tick(1);
    chk("err_pulse_end", load_err, 1'b0);
    set_time(16'h0A00); load = 1'b1; tick(1); load = 1'b0;
    chk("bad_min_err", {load_err, tm()}, {1'b1, 16'h0000});
    start = 1'b1; tick(1); start = 1'b0;
    chk("start_zero", fl(), 3'b000);
    tick(4);
    chk("start_zero_hold", {fl(), tm()}, {3'b000, 16'h0000});

    // pause two cycles in, hold, resume
    set_time(16'h0003); load = 1'b1; tick(1); load = 1'b0;
    start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    pause = 1'b1; tick(1); pause = 1'b0;
    chk("paused_flags", fl(), 3'b010);
    tick(10);
    chk("paused_frozen", {fl(), tm()}, {3'b010, 16'h0003});
    start = 1'b1; tick(1); start = 1'b0;
    chk("resume_run", {fl(), tm()}, {3'b100, 16'h0003});
    tick(1);
    chk("resume_no_dec", tm(), 16'h0003);
    tick(1);
    chk("resume_dec", tm(), 16'h0002);

    // pause on the wrap cycle suppresses the decrement
    tick(3);
    pause = 1'b1; tick(1); pause = 1'b0;
    chk("wrap_pause", {fl(), tm()}, {3'b010, 16'h0002});
    start = 1'b1; tick(1); start = 1'b0;
    chk("wrap_resume", tm(), 16'h0002);
    tick(1);
    chk("wrap_resume_dec", tm(), 16'h0001);

    // asynchronous reset mid-run
    tick(1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_time", tm(), 16'h0000);
    chk("async_rst_flags", {fl(), expired, load_err}, 5'b00000);
    #3 rst = 1'b0;
    tick(2);
    chk("post_rst_idle", {fl(), tm()}, {3'b000, 16'h0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
